freq_meter: RTL

//   Measures the period of a slow, asynchronous square wave, in cycles of clkin. It is the

---
 rtl/freq_meter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/freq_meter.sv
// freq_meter: measures the period of a slow asynchronous square wave in clkin cycles.
//
// Ports:
//   clkin   - system clock, rising edge
//   rst     - asynchronous active-high reset
//   sigin   - asynchronous input under measurement
//   en      - measurement enable (level)
//   period  - last measured rise-to-rise distance in clkin cycles (size bits)
//   valid   - one-cycle pulse, period updated
//   timeout - one-cycle pulse, counter saturated without a new rise
//   busy    - state is not IDLE
//
// Parameters: size (counter width), sync_len (synchronizer depth, 2 or 3).
// Optional macro FREQ_METER_AVG_EN: report the average of every 4 completed periods.

module freq_meter #(
  parameter int size     = 30,
  parameter int sync_len = 2
) (
  input  logic            clkin,
  input  logic            rst,
  input  logic            sigin,
  input  logic            en,
  output logic [size-1:0] period,
  output logic            valid,
  output logic            timeout,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

  localparam logic [size-1:0] CNT_MAX = '1;

  state_t                state_q;
  logic [sync_len-1:0]   sync_q;
  logic                  hist_q;
  logic [size-1:0]       cnt_q;
  logic [size-1:0]       period_q;
  logic                  valid_q;
  logic                  timeout_q;
  logic                  busy_q;
  logic                  rise;

  assign rise = sync_q[sync_len-1] & ~hist_q;

`ifdef FREQ_METER_AVG_EN
  logic [size+1:0] acc_q;
  logic [1:0]      smp_q;
  logic [size+1:0] acc_sum;

  // Sum including the period completing this cycle.
  assign acc_sum = acc_q + {2'b00, cnt_q};
`endif

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      hist_q    <= 1'b0;
      cnt_q     <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef FREQ_METER_AVG_EN
      acc_q     <= '0;
      smp_q     <= '0;
`endif
    end else begin
      sync_q    <= {sync_q[sync_len-2:0], sigin};
      hist_q    <= sync_q[sync_len-1];
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      if (!en) begin
        // Disable overrides everything, including a coincident rise.
        state_q <= IDLE;
        cnt_q   <= '0;
        busy_q  <= 1'b0;
`ifdef FREQ_METER_AVG_EN
        acc_q   <= '0;
        smp_q   <= '0;
`endif
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q   <= '0;
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
          ARM: begin
            busy_q <= 1'b1;
            // First edge only starts the count.
            if (rise) begin
              cnt_q   <= {{(size-1){1'b0}}, 1'b1};
              state_q <= MEAS;
            end
          end
          MEAS: begin
            busy_q <= 1'b1;
            if (rise) begin
              // Rise takes priority over saturation: period may equal CNT_MAX.
              cnt_q <= {{(size-1){1'b0}}, 1'b1};
`ifdef FREQ_METER_AVG_EN
              if (smp_q == 2'd3) begin
                period_q <= acc_sum[size+1:2];
                valid_q  <= 1'b1;
                acc_q    <= '0;
                smp_q    <= '0;
              end else begin
                acc_q <= acc_sum;
                smp_q <= smp_q + 2'd1;
              end
`else
              period_q <= cnt_q;
              valid_q  <= 1'b1;
`endif
            end else if (cnt_q == CNT_MAX) begin
              timeout_q <= 1'b1;
              cnt_q     <= '0;
              state_q   <= ARM;
`ifdef FREQ_METER_AVG_EN
              acc_q     <= '0;
              smp_q     <= '0;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign period  = period_q;
  assign valid   = valid_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;

endmodule
